// File: rtl/ibex_mult_pext_seq_pkg.sv
// Shared types for the P-extension SIMD multiplier and its two-pass sequencer.
package ibex_mult_pext_seq_pkg;

   typedef enum logic [2:0] {
      ZPN_SMUL16  = 3'd0,
      ZPN_UMUL16  = 3'd1,
      ZPN_SMULX16 = 3'd2,
      ZPN_UMULX16 = 3'd3,
      ZPN_SMUL8   = 3'd4,
      ZPN_UMUL8   = 3'd5,
      ZPN_SMULX8  = 3'd6,
      ZPN_UMULX8  = 3'd7
   } zpn_op_e;

   typedef enum logic [1:0] {
      S16 = 2'd0,
      U16 = 2'd1,
      S8  = 2'd2,
      U8  = 2'd3
   } signed_type_e;

   typedef enum logic [1:0] {
      MSEQ_IDLE = 2'd0,
      MSEQ_LO   = 2'd1,
      MSEQ_HI   = 2'd2,
      MSEQ_HOLD = 2'd3
   } mult_pext_seq_e;

   function automatic logic is_byte_op(input zpn_op_e op);
      return (op == ZPN_SMUL8) || (op == ZPN_UMUL8) ||
             (op == ZPN_SMULX8) || (op == ZPN_UMULX8);
   endfunction

   function automatic logic is_crossed_op(input zpn_op_e op);
      return (op == ZPN_SMULX16) || (op == ZPN_UMULX16) ||
             (op == ZPN_SMULX8) || (op == ZPN_UMULX8);
   endfunction

endpackage

// File: rtl/ibex_mult_pext_seq_if.sv
// Request/result bundle between ID/EX, the multiply sequencer and writeback.
interface ibex_mult_pext_seq_if;
   import ibex_mult_pext_seq_pkg::*;

   logic         en_i;
   zpn_op_e      operator_i;
   signed_type_e signed_operands_i;
   logic [31:0]  op_a_i;
   logic [31:0]  op_b_i;
   logic         kill_i;
   logic         ready_id_i;
   logic [63:0]  result_o;
   logic         valid_o;
   logic         busy_o;

   modport slave (
      input  en_i, operator_i, signed_operands_i, op_a_i, op_b_i, kill_i, ready_id_i,
      output result_o, valid_o, busy_o
   );

   modport master (
      output en_i, operator_i, signed_operands_i, op_a_i, op_b_i, kill_i, ready_id_i,
      input  result_o, valid_o, busy_o
   );
endinterface

// File: rtl/ibex_mult_pext.sv
// SIMD multiplier datapath: one half pass per call, selected by second_half_i.
module ibex_mult_pext
   import ibex_mult_pext_seq_pkg::*;
(
   input  zpn_op_e      operator_i,
   input  signed_type_e signed_operands_i,
   input  logic [31:0]  op_a_i,
   input  logic [31:0]  op_b_i,
   input  logic         second_half_i,
   output logic [31:0]  result_o
);

   logic        byte_s;
   logic        cross_s;
   logic        sgn_s;
   logic [15:0] a_h_s;
   logic [15:0] b_h_s;
   logic [7:0]  b_b0_s;
   logic [7:0]  b_b1_s;
   logic [31:0] prod_h_s;
   logic [15:0] prod_b0_s;
   logic [15:0] prod_b1_s;

   assign byte_s  = is_byte_op(operator_i);
   assign cross_s = is_crossed_op(operator_i);
   assign sgn_s   = (signed_operands_i == S16) || (signed_operands_i == S8);

   // Halfword crossing swaps the b half; byte crossing swaps bytes inside the half.
   assign a_h_s  = second_half_i ? op_a_i[31:16] : op_a_i[15:0];
   assign b_h_s  = (second_half_i ^ (cross_s & ~byte_s)) ? op_b_i[31:16] : op_b_i[15:0];
   assign b_b0_s = (cross_s & byte_s) ? b_h_s[15:8] : b_h_s[7:0];
   assign b_b1_s = (cross_s & byte_s) ? b_h_s[7:0]  : b_h_s[15:8];

   assign prod_h_s  = {{16{sgn_s & a_h_s[15]}}, a_h_s} * {{16{sgn_s & b_h_s[15]}}, b_h_s};
   assign prod_b0_s = {{8{sgn_s & a_h_s[7]}}, a_h_s[7:0]} * {{8{sgn_s & b_b0_s[7]}}, b_b0_s};
   assign prod_b1_s = {{8{sgn_s & a_h_s[15]}}, a_h_s[15:8]} * {{8{sgn_s & b_b1_s[7]}}, b_b1_s};

   assign result_o = byte_s ? {prod_b1_s, prod_b0_s} : prod_h_s;

endmodule

// File: rtl/ibex_mult_pext_seq.sv
// Two-pass sequencer: low halves, then high halves, presenting a 64-bit pair result.
module ibex_mult_pext_seq
   import ibex_mult_pext_seq_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ibex_mult_pext_seq_if.slave   bus
);

   mult_pext_seq_e state_q;
   logic [31:0]    lo_q;
   logic [31:0]    hi_q;
   logic [31:0]    dp_result_s;
   logic           second_half_s;
   logic           abort_s;
   logic           valid_s;
   logic [63:0]    result_s;

   assign second_half_s = (state_q == MSEQ_HI);

   ibex_mult_pext u_mult_pext (
      .operator_i        (bus.operator_i),
      .signed_operands_i (bus.signed_operands_i),
      .op_a_i            (bus.op_a_i),
      .op_b_i            (bus.op_b_i),
      .second_half_i     (second_half_s),
      .result_o          (dp_result_s)
   );

   // Dropping en_i mid-operation is handled exactly like a flush.
   assign abort_s = bus.kill_i | (~bus.en_i & (state_q != MSEQ_IDLE));
   assign valid_s = ((state_q == MSEQ_HI) || (state_q == MSEQ_HOLD)) & ~abort_s;

   always_comb begin
      result_s = 64'd0;
      if (valid_s) begin
         if (state_q == MSEQ_HI) begin
            result_s = {dp_result_s, lo_q};
         end else begin
            result_s = {hi_q, lo_q};
         end
      end else begin
         result_s = 64'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= MSEQ_IDLE;
         lo_q    <= 32'd0;
         hi_q    <= 32'd0;
      end else if (abort_s) begin
         state_q <= MSEQ_IDLE;
      end else begin
         case (state_q)
            MSEQ_IDLE: begin
               if (bus.en_i) state_q <= MSEQ_LO;
            end
            MSEQ_LO: begin
               lo_q    <= dp_result_s;
               state_q <= MSEQ_HI;
            end
            MSEQ_HI: begin
               if (bus.ready_id_i) begin
                  state_q <= MSEQ_IDLE;
               end else begin
                  hi_q    <= dp_result_s;
                  state_q <= MSEQ_HOLD;
               end
            end
            MSEQ_HOLD: begin
               if (bus.ready_id_i) state_q <= MSEQ_IDLE;
            end
            default: state_q <= MSEQ_IDLE;
         endcase
      end
   end

   assign bus.result_o = result_s;
   assign bus.valid_o  = valid_s;
   assign bus.busy_o   = (state_q != MSEQ_IDLE);

endmodule
